// File: rtl/sonar_frame_scheduler.sv
// Ultrasonic ranging sequencer: periodic trigger, echo timing in cm, framed result via uart_tx start/done handshake.
// Define SONAR_CHECKSUM_EN to append an XOR checksum byte (4-byte packet instead of 3).
module sonar_frame_scheduler #(
  parameter int unsigned TRIG_CYCLES    = 120,
  parameter int unsigned CM_CYCLES      = 696,
  parameter int unsigned TIMEOUT_CYCLES = 300000,
  parameter int unsigned PERIOD_CYCLES  = 720000,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       echo,
  output logic       trigger,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_done,
  output logic [7:0] distance,
  output logic       dist_valid,
  output logic       busy
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_TRIG      = 3'd1;
  localparam logic [2:0] S_WAIT_RISE = 3'd2;
  localparam logic [2:0] S_MEASURE   = 3'd3;
  localparam logic [2:0] S_LATCH     = 3'd4;
  localparam logic [2:0] S_SEND      = 3'd5;
  localparam logic [2:0] S_WAIT_DONE = 3'd6;

`ifdef SONAR_CHECKSUM_EN
  localparam logic [1:0] LAST_IDX = 2'd3;
`else
  localparam logic [1:0] LAST_IDX = 2'd2;
`endif

  logic [2:0]  state;
  logic [31:0] per_cnt;
  logic        first;
  logic [31:0] tmr;
  logic [31:0] presc;
  logic [7:0]  cm;
  logic        sat;
  logic        timeout;
  logic [1:0]  idx;
  logic [5:0]  seq;
  logic        echo_meta, echo_s, echo_d;
  logic        rise;
  logic [7:0]  status;
  logic [7:0]  pkt_byte;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      echo_meta <= 1'b0;
      echo_s    <= 1'b0;
      echo_d    <= 1'b0;
    end else begin
      echo_meta <= echo;
      echo_s    <= echo_meta;
      echo_d    <= echo_s;
    end
  end

  assign rise   = echo_s & ~echo_d;
  assign status = {seq, sat, timeout};

  always_comb begin
    pkt_byte = SYNC_BYTE;
    case (idx)
      2'd0:    pkt_byte = SYNC_BYTE;
      2'd1:    pkt_byte = distance;
      2'd2:    pkt_byte = status;
`ifdef SONAR_CHECKSUM_EN
      2'd3:    pkt_byte = SYNC_BYTE ^ distance ^ status;
`endif
      default: pkt_byte = SYNC_BYTE;
    endcase
  end

  // The rise-detect cycle already has echo high, so it counts as the first
  // prescaler tick (presc starts at 1; CM_CYCLES must be >= 2).
  // `first` lets the trigger fire right after reset while the period counter
  // still starts from its full reload value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      per_cnt  <= PERIOD_CYCLES - 1;
      first    <= 1'b1;
      tmr      <= '0;
      presc    <= '0;
      cm       <= '0;
      sat      <= 1'b0;
      timeout  <= 1'b0;
      distance <= '0;
      idx      <= '0;
      seq      <= '0;
    end else begin
      if (per_cnt != '0) per_cnt <= per_cnt - 32'd1;
      case (state)
        S_IDLE: begin
          if (per_cnt == '0 || first) begin
            state   <= S_TRIG;
            per_cnt <= PERIOD_CYCLES - 1;
            first   <= 1'b0;
            tmr     <= '0;
          end
        end
        S_TRIG: begin
          if (tmr == TRIG_CYCLES - 1) begin
            state <= S_WAIT_RISE;
            tmr   <= '0;
          end else begin
            tmr <= tmr + 32'd1;
          end
        end
        S_WAIT_RISE: begin
          if (rise) begin
            state   <= S_MEASURE;
            presc   <= 32'd1;
            cm      <= '0;
            sat     <= 1'b0;
            timeout <= 1'b0;
            tmr     <= 32'd1;
          end else if (tmr == TIMEOUT_CYCLES - 1) begin
            state    <= S_LATCH;
            sat      <= 1'b0;
            timeout  <= 1'b1;
            distance <= 8'hFF;
          end else begin
            tmr <= tmr + 32'd1;
          end
        end
        S_MEASURE: begin
          // A fall on the cycle the timeout would expire wins as a normal fall.
          if (!echo_s) begin
            state    <= S_LATCH;
            timeout  <= 1'b0;
            distance <= cm;
          end else if (tmr == TIMEOUT_CYCLES) begin
            state    <= S_LATCH;
            timeout  <= 1'b1;
            distance <= 8'hFF;
          end else begin
            tmr <= tmr + 32'd1;
            if (presc == CM_CYCLES - 1) begin
              presc <= '0;
              if (cm == 8'hFF) sat <= 1'b1;
              else             cm  <= cm + 8'd1;
            end else begin
              presc <= presc + 32'd1;
            end
          end
        end
        S_LATCH: begin
          idx   <= '0;
          state <= S_SEND;
        end
        S_SEND: state <= S_WAIT_DONE;
        S_WAIT_DONE: begin
          if (tx_done) begin
            if (idx == LAST_IDX) begin
              state <= S_IDLE;
              seq   <= seq + 6'd1;
            end else begin
              idx   <= idx + 2'd1;
              state <= S_SEND;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign trigger    = (state == S_TRIG);
  assign tx_start   = (state == S_SEND);
  assign tx_data    = (state == S_SEND) ? pkt_byte : '0;
  assign dist_valid = (state == S_LATCH);
  assign busy       = (state != S_IDLE);

endmodule

// File: tb/tb_sonar_frame_scheduler.sv
// Scoreboard bench for sonar_frame_scheduler with scaled-down timing parameters.
module tb_sonar_frame_scheduler;

  localparam int TRIG = 8;
  localparam int CM   = 4;
  localparam int TMO  = 1100;
  localparam int PER  = 400;
  localparam logic [7:0] SYNC = 8'hA5;
`ifdef SONAR_CHECKSUM_EN
  localparam int PKT_LEN = 4;
`else
  localparam int PKT_LEN = 3;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic echo = 1'b0;
  logic resp_done = 1'b0;
  logic spur_done = 1'b0;
  logic tx_done;
  logic trigger, tx_start, dist_valid, busy;
  logic [7:0] tx_data, distance;

  assign tx_done = resp_done | spur_done;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [7:0] exp_bytes[$];
  logic [7:0] exp_dist[$];
  int seq_model = 0;
  int prev_rise = 0;
  int last_done = -1000000;
  bit after_reset = 1'b1;
  int rel_cyc = 0;
  int hold_byte = -1;
  int hold_len = 0;

  sonar_frame_scheduler #(
    .TRIG_CYCLES(TRIG),
    .CM_CYCLES(CM),
    .TIMEOUT_CYCLES(TMO),
    .PERIOD_CYCLES(PER),
    .SYNC_BYTE(SYNC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .echo(echo),
    .trigger(trigger),
    .tx_start(tx_start),
    .tx_data(tx_data),
    .tx_done(tx_done),
    .distance(distance),
    .dist_valid(dist_valid),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected packet from the ranging rules: width in whole cm, clipped at 255,
  // 0xFF on timeout (no rise, or echo high longer than the timeout).
  task automatic push_frame(input bit has_echo, input int n);
    logic [7:0] d, st;
    bit to, sat;
    int k;
    if (!has_echo) begin
      to = 1'b1; sat = 1'b0; d = 8'hFF;
    end else begin
      k   = (n > TMO) ? TMO : n;
      to  = (n > TMO);
      sat = (k / CM) > 255;
      d   = (to || sat) ? 8'hFF : 8'(k / CM);
    end
    st = {6'(seq_model), sat, to};
    exp_bytes.push_back(SYNC);
    exp_bytes.push_back(d);
    exp_bytes.push_back(st);
`ifdef SONAR_CHECKSUM_EN
    exp_bytes.push_back(SYNC ^ d ^ st);
`endif
    exp_dist.push_back(d);
    seq_model = (seq_model + 1) % 64;
  endtask

  task automatic wait_level(input logic val, input string what);
    int t = 0;
    while (trigger !== val && t < 4000) begin
      @(negedge clk);
      t++;
    end
    check(what, trigger, val);
  endtask

  task automatic drive_echo(input int dly, input int n);
    repeat (dly) @(negedge clk);
    echo = 1'b1;
    repeat (n) @(negedge clk);
    echo = 1'b0;
  endtask

  task automatic run_frame(input bit has_echo, input int dly, input int n);
    wait_level(1'b1, "trig_rise_wait");
    wait_level(1'b0, "trig_fall_wait");
    push_frame(has_echo, n);
    if (has_echo) drive_echo(dly, n);
  endtask

  task automatic check_reset_outputs();
    check("rst_trigger", trigger, 0);
    check("rst_tx_start", tx_start, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_distance", distance, 0);
    check("rst_dist_valid", dist_valid, 0);
    check("rst_busy", busy, 0);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1 check_reset_outputs();
    echo = 1'b0;
    exp_bytes.delete();
    exp_dist.delete();
    seq_model = 0;
    after_reset = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    rel_cyc = cyc;
  endtask

  // uart_tx stand-in: answers each tx_start with a one-cycle tx_done
  initial begin : responder
    int pend;
    int bidx;
    pend = 0;
    bidx = 0;
    forever begin
      @(negedge clk);
      resp_done = 1'b0;
      if (!rst_n) begin
        pend = 0;
        bidx = 0;
      end else begin
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            resp_done = 1'b1;
            if (bidx == PKT_LEN - 1) begin
              bidx = 0;
              last_done = cyc;
            end else begin
              bidx++;
            end
          end
        end
        if (tx_start) begin
          check("tx_start_while_pending", pend, 0);
          pend = (hold_byte == bidx) ? hold_len : 5;
        end
      end
    end
  end

  initial begin : trig_mon
    logic prev_t;
    int width;
    int exp_rise;
    prev_t = 1'b0;
    width = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_t = 1'b0;
        width = 0;
      end else begin
        if (cyc == last_done + 1) check("idle_after_packet", busy, 0);
        if (trigger && !prev_t) begin
          if (after_reset) exp_rise = rel_cyc + 1;
          else exp_rise = (prev_rise + PER > last_done + 2) ? prev_rise + PER : last_done + 2;
          check("trigger_rise_cycle", cyc, exp_rise);
          check("busy_in_trig", busy, 1);
          prev_rise = cyc;
          after_reset = 1'b0;
          width = 0;
        end
        if (trigger) width++;
        if (!trigger && prev_t) check("trigger_width", width, TRIG);
        prev_t = trigger;
      end
    end
  end

  initial begin : out_mon
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && tx_start) begin
        if (exp_bytes.size() == 0) check("unexpected_tx_start", 0, 1);
        else begin
          e = exp_bytes.pop_front();
          check("tx_data", tx_data, e);
        end
      end
      if (rst_n && dist_valid) begin
        if (exp_dist.size() == 0) check("unexpected_dist_valid", 0, 1);
        else begin
          e = exp_dist.pop_front();
          check("distance", distance, e);
        end
      end
    end
  end

  initial begin : stim
    int t;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs();
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    rel_cyc = cyc;

    run_frame(1'b0, 0, 0);
    run_frame(1'b1, 25, 10 * CM);
    run_frame(1'b1, 20, 10 * CM - 1);
    run_frame(1'b1, 15, 1050);
    run_frame(1'b1, 15, TMO);
    run_frame(1'b1, 15, TMO + 1);

    // echo already high when WAIT_RISE is entered: no rise, so a timeout
    wait_level(1'b1, "trig_rise_wait");
    echo = 1'b1;
    wait_level(1'b0, "trig_fall_wait");
    push_frame(1'b0, 0);
    repeat (30) @(negedge clk);
    echo = 1'b0;

    // byte 1 held off past the period
    hold_byte = 1;
    hold_len = 2 * PER;
    run_frame(1'b1, 10, 60);
    wait_level(1'b1, "trig_rise_wait");
    hold_byte = -1;

    // spurious tx_done while measuring
    wait_level(1'b0, "trig_fall_wait");
    push_frame(1'b1, 80);
    repeat (10) @(negedge clk);
    echo = 1'b1;
    repeat (20) @(negedge clk);
    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    repeat (59) @(negedge clk);
    echo = 1'b0;

    // reset during MEASURE
    wait_level(1'b1, "trig_rise_wait");
    wait_level(1'b0, "trig_fall_wait");
    repeat (5) @(negedge clk);
    echo = 1'b1;
    repeat (30) @(negedge clk);
    do_reset();

    run_frame(1'b1, 12, 37);

    // reset during WAIT_DONE
    run_frame(1'b1, 8, 40);
    t = 0;
    while (!tx_start && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("tx_start_seen", tx_start, 1);
    repeat (2) @(negedge clk);
    do_reset();

    for (int i = 0; i < 66; i++)
      run_frame(1'b1, $urandom_range(40, 1), $urandom_range(300, 1));

    t = 0;
    while ((exp_bytes.size() != 0 || exp_dist.size() != 0) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("bytes_drained", exp_bytes.size(), 0);
    check("dist_drained", exp_dist.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
